// File: rtl/trivia_data_sched.sv
// Front-end scheduler for the TriviA core: takes one AD/message command, streams
// 64-bit words to the core one per request, padding the last partial word of each phase.
module trivia_data_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_adlen,
  input  logic [63:0] cmd_msglen,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din_data,
  output logic        core_start,
  output logic [63:0] core_adlen,
  output logic [63:0] core_msglen,
  input  logic        core_word_req,
  output logic [63:0] core_word,
  output logic        core_word_valid,
  input  logic        core_done,
  output logic        busy,
  output logic        underrun
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_AD    = 3'd2;
  localparam logic [2:0] ST_MSG   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  logic [2:0]  state_reg;
  logic [63:0] words_ad_reg, words_msg_reg, words_left_reg, words_fetched_reg;
  logic [2:0]  r_ad_reg, r_msg_reg;
  logic        zero_ad_reg, zero_msg_reg;
  logic [63:0] hold_reg;
  logic        hold_valid_reg;
  logic        underrun_reg;
  logic [63:0] adlen_reg, msglen_reg;

  // ceil(len/8) without a 65-bit adder: whole words plus one for any tail bytes
  logic [63:0] ad_words_c, msg_words_c;
  assign ad_words_c  = (cmd_adlen == 64'd0) ? 64'd1 :
                       {3'b0, cmd_adlen[63:3]} + {63'b0, |cmd_adlen[2:0]};
  assign msg_words_c = (cmd_msglen == 64'd0) ? 64'd1 :
                       {3'b0, cmd_msglen[63:3]} + {63'b0, |cmd_msglen[2:0]};

  logic        in_phase, drain, last_drain, tgt_msg, tgt_ok, tgt_zero;
  logic        can_load, load, load_last;
  logic [63:0] tgt_fetched, tgt_words, pad_word, load_word;
  logic [2:0]  tgt_r;

  assign in_phase   = (state_reg == ST_AD) || (state_reg == ST_MSG);
  assign drain      = core_word_req && hold_valid_reg && in_phase;
  assign last_drain = drain && (words_left_reg == 64'd1);

  // A fetch during the drain of the last AD word already belongs to the message phase
  assign tgt_msg     = (state_reg == ST_MSG) || last_drain;
  assign tgt_ok      = (state_reg == ST_AD) || ((state_reg == ST_MSG) && !last_drain);
  assign tgt_fetched = ((state_reg == ST_AD) && last_drain) ? 64'd0 : words_fetched_reg;
  assign tgt_words   = tgt_msg ? words_msg_reg : words_ad_reg;
  assign tgt_zero    = tgt_msg ? zero_msg_reg : zero_ad_reg;
  assign tgt_r       = tgt_msg ? r_msg_reg : r_ad_reg;

  assign can_load  = (!hold_valid_reg || drain) && tgt_ok && (tgt_fetched < tgt_words);
  assign din_ready = can_load && !tgt_zero;
  assign load      = can_load && (tgt_zero || din_valid);
  assign load_last = (tgt_fetched + 64'd1) == tgt_words;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pad
      assign pad_word[63-8*gi -: 8] = (3'(gi) < tgt_r)  ? din_data[63-8*gi -: 8] :
                                      (3'(gi) == tgt_r) ? 8'h80 : 8'h00;
    end
  endgenerate

  assign load_word = tgt_zero ? 64'h8000_0000_0000_0000 :
                     (load_last && (tgt_r != 3'd0)) ? pad_word : din_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      words_ad_reg      <= 64'd0;
      words_msg_reg     <= 64'd0;
      words_left_reg    <= 64'd0;
      words_fetched_reg <= 64'd0;
      r_ad_reg          <= 3'd0;
      r_msg_reg         <= 3'd0;
      zero_ad_reg       <= 1'b0;
      zero_msg_reg      <= 1'b0;
      hold_reg          <= 64'd0;
      hold_valid_reg    <= 1'b0;
      underrun_reg      <= 1'b0;
      adlen_reg         <= 64'd0;
      msglen_reg        <= 64'd0;
    end else begin
      if (core_word_req && !(hold_valid_reg && in_phase))
        underrun_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            words_ad_reg  <= ad_words_c;
            words_msg_reg <= msg_words_c;
            r_ad_reg      <= cmd_adlen[2:0];
            r_msg_reg     <= cmd_msglen[2:0];
            zero_ad_reg   <= (cmd_adlen == 64'd0);
            zero_msg_reg  <= (cmd_msglen == 64'd0);
            adlen_reg     <= ad_words_c << 3;
            msglen_reg    <= msg_words_c << 3;
            underrun_reg  <= 1'b0;
            state_reg     <= ST_START;
          end
        end
        ST_START: begin
          words_left_reg    <= words_ad_reg;
          words_fetched_reg <= 64'd0;
          state_reg         <= ST_AD;
        end
        ST_AD, ST_MSG: begin
          if (drain) begin
            if (last_drain) begin
              if (state_reg == ST_AD) begin
                state_reg      <= ST_MSG;
                words_left_reg <= words_msg_reg;
              end else begin
                state_reg <= ST_WAIT;
              end
            end else begin
              words_left_reg <= words_left_reg - 64'd1;
            end
          end
          words_fetched_reg <= tgt_fetched + {63'b0, load};
          if (load) begin
            hold_reg       <= load_word;
            hold_valid_reg <= 1'b1;
          end else if (drain) begin
            hold_reg       <= 64'd0;
            hold_valid_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (core_done)
            state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state_reg == ST_IDLE);
  assign busy            = (state_reg != ST_IDLE);
  assign core_start      = (state_reg == ST_START);
  assign core_adlen      = adlen_reg;
  assign core_msglen     = msglen_reg;
  assign core_word       = hold_reg;
  assign core_word_valid = hold_valid_reg;
  assign underrun        = underrun_reg;

endmodule

// File: doc/trivia_data_sched.md
# trivia_data_sched

Front-end scheduler for the TriviA core FSM and datapath. It accepts one encryption command (associated-data and message byte lengths) and a stream of 64-bit input words over valid/ready handshakes. It delivers the words to the core one per core request, with the final partial word of each phase padded. It also drives the core's start pulse and its word-aligned length inputs, and holds off new commands until the core reports completion.

## Interface
Parameters:
- none; word width is fixed at 64 bits (8 bytes, byte 0 in bits [63:56]).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_adlen  in  64  associated-data length, bytes
- cmd_msglen  in  64  message length, bytes
- din_valid  in  1  input word offered
- din_ready  out  1  word accepted when din_valid & din_ready
- din_data  in  64  input word
- core_start  out  1  one-cycle start pulse to core
- core_adlen  out  64  word-aligned AD length for core, stable from core_start until idle
- core_msglen  out  64  word-aligned message length for core, same stability
- core_word_req  in  1  core consumes core_word this cycle (its process_data)
- core_word  out  64  current word, padded as required
- core_word_valid  out  1  holding register full
- core_done  in  1  core has finished the message-phase tag update
- busy  out  1  high in every state except IDLE
- underrun  out  1  sticky error; cleared only by reset or by the next command acceptance

## Operation
- States: IDLE, START, AD, MSG, WAIT_DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch words_ad = max(ceil(cmd_adlen/8),1) and words_msg = max(ceil(cmd_msglen/8),1).
  - Latch tail bytes r_ad = cmd_adlen[2:0] and r_msg = cmd_msglen[2:0], plus zero flags for each length.
  - Clear underrun, then go to START.
- Arithmetic: ceil computed as (len+7)>>3 in 65 bits. core_adlen = words_ad<<3 and core_msglen = words_msg<<3, truncated to 64 bits.
- START: core_start=1 for exactly this cycle, then go to AD. words_left is loaded with words_ad.
- AD and MSG share one datapath:
  - A one-entry holding register feeds core_word.
  - din_ready = (holding empty | core_word_req) & (words_fetched < words of the current phase) & not a zero-length phase.
  - Fetch and drain in the same cycle is legal. A fetch in the drain cycle of the phase's last word belongs to the next phase.
- Padding is applied when a word enters the holding register and it is the phase's last word with r≠0:
  - bytes 0..r-1 are kept from din_data;
  - byte r = 0x80;
  - bytes r+1..7 = 0x00.
- r=0 with nonzero length: last word is unpadded.
- Zero-length phase: the holding register self-loads 0x8000_0000_0000_0000 without a din handshake.
- Each core_word_req decrements words_left.
  - When words_left reaches 1 and is requested, AD goes to MSG (reload with words_msg) and MSG goes to WAIT_DONE.
- core_word_req with holding empty, or in IDLE/START/WAIT_DONE: set underrun, drive core_word=0, counters unchanged.
- WAIT_DONE: din_ready=0. On core_done go to IDLE. core_done in any other state is ignored.

## Timing
- Reset values:
  - state=IDLE;
  - cmd_ready=1;
  - din_ready=0;
  - core_start=0;
  - core_adlen=core_msglen=0;
  - core_word=0;
  - core_word_valid=0;
  - busy=0;
  - underrun=0.
- Reset mid-operation: all of the above take effect immediately (asynchronous). The holding word is discarded.
- Command acceptance is in cycle N. core_start is high in N+1. The first din_ready is possible in N+2.
- The core spends its init rounds after core_start. The scheduler prefetches one word during that time, so with din_valid held high there is zero underrun.
- Throughput: one word per cycle sustained when din_valid and core_word_req are both continuously high.
- core_word and core_word_valid are registered outputs. The word consumed in cycle T is replaced by the next one at T+1 if it was fetched at T.
- busy deasserts, and cmd_ready asserts, the cycle after core_done is sampled.

## Test plan
- adlen=16, msglen=24, din words 0x1111…,0x2222…,0x3333…,0x4444…,0x5555… with core_word_req every cycle after init:
  - core_adlen=16, core_msglen=24;
  - five words delivered unmodified in order;
  - busy drops one cycle after core_done.
- adlen=3, msglen=13, din AABBCC…, then two message words:
  - AD word = 0xAABBCC8000000000;
  - second message word keeps 5 bytes, then 0x80 and 0x00.
- adlen=0, msglen=0:
  - no din handshakes;
  - two words 0x8000000000000000 delivered;
  - core_adlen=core_msglen=8.
- din_valid low while core_word_req pulses: underrun=1 and core_word=0. A new command clears underrun.
- rst asserted while in MSG with the holding register full:
  - all outputs return to reset values within the same cycle;
  - the next command runs normally.
- cmd_valid held high throughout a command: no second acceptance until core_done. The second command's core_start follows one cycle after acceptance.
